// File: rtl/mul_div_unit_if.sv
// Execute-stage handshake between the ID/EX register, the mul/div unit and write-back.
// master drives the operation request and flush; slave returns stall, result and destination.
interface mul_div_unit_if;
  logic        mulDivEnEX;
  logic [2:0]  mulDivOpEX;
  logic [31:0] operandAEX;
  logic [31:0] operandBEX;
  logic [4:0]  rdAddrEX;
  logic        flushEX;
  logic        stallMD;
  logic        doneMD;
  logic [31:0] resultMD;
  logic [4:0]  rdAddrMD;

  modport master (
    output mulDivEnEX, mulDivOpEX, operandAEX, operandBEX, rdAddrEX, flushEX,
    input  stallMD, doneMD, resultMD, rdAddrMD
  );

  modport slave (
    input  mulDivEnEX, mulDivOpEX, operandAEX, operandBEX, rdAddrEX, flushEX,
    output stallMD, doneMD, resultMD, rdAddrMD
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M mul/div: multiply done 2 cycles after start, divide 33 (div-by-zero/overflow 1).
// Back-pressure is stallMD, held from the start cycle until the cycle before the one-cycle doneMD.
module mul_div_unit (
  input  logic           clk,
  input  logic           arstn,
  mul_div_unit_if.slave  md
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state, state_n;
  logic [31:0] a_q, b_q, rem_q, result_q;
  logic [2:0]  op_q;
  logic [4:0]  rd_q, rdaddr_q, cnt_q;
  logic        mul_sa_q, mul_sb_q, qneg_q, rneg_q;

  logic        sdiv, div_zero, div_ovf, fast;
  logic [31:0] spec_res;
  logic [65:0] mul_a, mul_b, prod;
  logic [32:0] shifted, diff;
  logic        qbit;
  logic [31:0] rem_nxt, quo_nxt, div_res;

  // Operand checks on the incoming (not yet latched) instruction
  assign sdiv     = md.mulDivOpEX[2] & ~md.mulDivOpEX[0];
  assign div_zero = (md.operandBEX == 32'd0);
  assign div_ovf  = sdiv & (md.operandAEX == 32'h8000_0000) & (md.operandBEX == 32'hFFFF_FFFF);
  assign fast     = md.mulDivOpEX[2] & (div_zero | div_ovf);
  assign spec_res = div_zero ? (md.mulDivOpEX[1] ? md.operandAEX : 32'hFFFF_FFFF)
                             : (md.mulDivOpEX[1] ? 32'd0 : 32'h8000_0000);

  // 33x33 signed product; only the low 64 bits are ever used
  assign mul_a = {{34{mul_sa_q & a_q[31]}}, a_q};
  assign mul_b = {{34{mul_sb_q & b_q[31]}}, b_q};
  assign prod  = mul_a * mul_b;

  // One restoring step: a_q shifts the dividend out and the quotient in
  assign shifted = {rem_q, a_q[31]};
  assign diff    = shifted - {1'b0, b_q};
  assign qbit    = ~diff[32];
  assign rem_nxt = qbit ? diff[31:0] : shifted[31:0];
  assign quo_nxt = {a_q[30:0], qbit};
  assign div_res = op_q[1] ? (rneg_q ? -rem_nxt : rem_nxt)
                           : (qneg_q ? -quo_nxt : quo_nxt);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    md.stallMD = 1'b0;
    md.doneMD  = 1'b0;
    case (state)
      S_IDLE: begin
        if (md.mulDivEnEX) begin
          md.stallMD = 1'b1;
          if (!md.mulDivOpEX[2]) state_n = S_MUL;
          else if (fast)         state_n = S_DONE;
          else                   state_n = S_DIV;
        end
      end
      S_MUL: begin
        md.stallMD = 1'b1;
        state_n    = S_DONE;
      end
      S_DIV: begin
        md.stallMD = 1'b1;
        if (cnt_q == 5'd31) state_n = S_DONE;
      end
      S_DONE: begin
        md.doneMD = 1'b1;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (md.flushEX) begin
      state_n    = S_IDLE;
      md.stallMD = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      mul_sa_q <= 1'b0;
      mul_sb_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      rdaddr_q <= '0;
    end else if (!md.flushEX) begin
      case (state)
        S_IDLE: begin
          if (md.mulDivEnEX) begin
            a_q      <= (sdiv & md.operandAEX[31]) ? -md.operandAEX : md.operandAEX;
            b_q      <= (sdiv & md.operandBEX[31]) ? -md.operandBEX : md.operandBEX;
            rem_q    <= '0;
            cnt_q    <= '0;
            op_q     <= md.mulDivOpEX;
            rd_q     <= md.rdAddrEX;
            mul_sa_q <= ~md.mulDivOpEX[2] & (md.mulDivOpEX[1:0] != 2'd3);
            mul_sb_q <= ~md.mulDivOpEX[2] & ~md.mulDivOpEX[1];
            qneg_q   <= sdiv & (md.operandAEX[31] ^ md.operandBEX[31]);
            rneg_q   <= sdiv & md.operandAEX[31];
            if (fast) begin
              result_q <= spec_res;
              rdaddr_q <= md.rdAddrEX;
            end
          end
        end
        S_MUL: begin
          result_q <= (op_q == 3'd0) ? prod[31:0] : prod[63:32];
          rdaddr_q <= rd_q;
        end
        S_DIV: begin
          a_q   <= quo_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q <= div_res;
            rdaddr_q <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign md.resultMD = result_q;
  assign md.rdAddrMD = rdaddr_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: the driver queues reference results, a monitor checks each doneMD.
// Covers directed RV32M corner cases, flush/reset mid-divide and randomized back-to-back ops.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_div_unit_if md ();

  mul_div_unit dut (
    .clk   (clk),
    .arstn (arstn),
    .md    (md.slave)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // RV32M semantics expressed with plain 64-bit and signed 32-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] as, bs, au, bu, p;
    logic        ovf;
    as  = {{32{a[31]}}, a};
    bs  = {{32{b[31]}}, b};
    au  = {32'd0, a};
    bu  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = as * bs; return p[31:0]; end
      3'd1: begin p = as * bs; return p[63:32]; end
      3'd2: begin p = as * bu; return p[63:32]; end
      3'd3: begin p = au * bu; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op into "ID/EX" and hold it there until the unit reports done
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int t, lat, stalls, seen;
    exp_t e;
    @(posedge clk);
    #1;
    md.flushEX    = 1'b0;
    md.mulDivEnEX = 1'b1;
    md.mulDivOpEX = op;
    md.operandAEX = a;
    md.operandBEX = b;
    md.rdAddrEX   = rd;
    t     = cyc;
    lat   = latency(op, a, b);
    e.res = model(op, a, b);
    e.rd  = rd;
    e.cyc = t + lat;
    exp_q.push_back(e);
    stalls = 0;
    seen   = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(negedge clk);
      if (md.stallMD) stalls++;
      if (md.doneMD) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(lat));
  endtask

  task automatic go_idle(input int n);
    @(posedge clk);
    #1;
    md.mulDivEnEX = 1'b0;
    md.flushEX    = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Monitor: every doneMD must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (arstn && md.doneMD === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", md.resultMD, e.res);
        chk("rd_addr", 32'(md.rdAddrMD), 32'(e.rd));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int t;
    md.mulDivEnEX = 1'b0;
    md.mulDivOpEX = '0;
    md.operandAEX = '0;
    md.operandBEX = '0;
    md.rdAddrEX   = '0;
    md.flushEX    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 32'(md.stallMD), 32'd0);
    chk("rst_done", 32'(md.doneMD), 32'd0);
    chk("rst_result", md.resultMD, 32'd0);
    chk("rst_rd", 32'(md.rdAddrMD), 32'd0);
    arstn = 1'b1;

    // Directed corner cases, issued back to back
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1);
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd2);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op(3'd5, 32'd100, 32'd7, 5'd7);
    run_op(3'd7, 32'd100, 32'd7, 5'd8);
    run_op(3'd4, 32'd5, 32'd0, 5'd9);
    run_op(3'd7, 32'd5, 32'd0, 5'd10);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    go_idle(2);

    // Flush a divide ten cycles in, then a multiply must start cleanly
    @(posedge clk);
    #1;
    md.mulDivEnEX = 1'b1;
    md.mulDivOpEX = 3'd5;
    md.operandAEX = 32'd1000;
    md.operandBEX = 32'd3;
    md.rdAddrEX   = 5'd12;
    t = cyc;
    while (cyc < t + 10) begin
      @(posedge clk);
      #1;
    end
    md.flushEX = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(md.stallMD), 32'd0);
    chk("flush_done", 32'(md.doneMD), 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 5'd13);
    go_idle(40);

    // Asynchronous reset in the middle of a divide
    run_op(3'd0, 32'd5, 32'd6, 5'd14);
    @(posedge clk);
    #1;
    md.mulDivEnEX = 1'b1;
    md.mulDivOpEX = 3'd4;
    md.operandAEX = 32'd77;
    md.operandBEX = 32'd5;
    md.rdAddrEX   = 5'd15;
    t = cyc;
    while (cyc < t + 5) begin
      @(posedge clk);
      #1;
    end
    arstn = 1'b0;
    md.mulDivEnEX = 1'b0;
    #1;
    chk("midrst_stall", 32'(md.stallMD), 32'd0);
    chk("midrst_done", 32'(md.doneMD), 32'd0);
    chk("midrst_result", md.resultMD, 32'd0);
    chk("midrst_rd", 32'(md.rdAddrMD), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    arstn = 1'b1;
    run_op(3'd5, 32'd9, 32'd3, 5'd16);

    // Randomized back-to-back ops with biased special operands
    for (int i = 0; i < 48; i++) begin
      logic [31:0] a, b;
      logic [2:0]  op;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'h8000_0000;
        4: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(op, a, b, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) go_idle(1);
    end
    go_idle(5);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
